// File: rtl/gmii_rx_deframer_if.sv
// Byte-wide AXI-stream carrying deframed receive payload.
//   tdata  : payload byte
//   tvalid : one-cycle beat strobe (no backpressure; the consumer is a FIFO)
//   tlast  : last payload byte of the frame
//   tuser  : bad-frame flag, meaningful only together with tlast
interface gmii_rx_deframer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, tvalid, tlast, tuser);
    modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/gmii_rx_deframer.sv
// Receive-side MAC framing stage: strips preamble/SFD, pairs nibbles in
// 10/100 mode, holds back the 4 FCS bytes, checks CRC-32 and emits the
// payload as a byte stream with tlast/tuser.
// Ports:
//   clk, rst_n       : receive clock, asynchronous active-low reset
//   clk_enable       : qualifies each GMII sample
//   mii_select       : 1 = nibble mode (rxd[3:0]), 0 = byte mode
//   gmii_rxd/_rx_dv/_rx_er : GMII receive inputs
//   m_axis           : payload stream (master)
//   error_bad_frame  : pulse on rx_er, odd nibble count or short frame
//   error_bad_fcs    : pulse on FCS mismatch
module gmii_rx_deframer #(
    parameter bit          ENABLE_MII = 1'b1,
    parameter int unsigned MIN_BYTES  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_enable,
    input  logic                      mii_select,
    input  logic [7:0]                gmii_rxd,
    input  logic                      gmii_rx_dv,
    input  logic                      gmii_rx_er,
    gmii_rx_deframer_if.master        m_axis,
    output logic                      error_bad_frame,
    output logic                      error_bad_fcs
);

    localparam int unsigned FCS_BYTES = 4;
    localparam int unsigned HOLD      = FCS_BYTES + 1;
    localparam int unsigned CNT_MAX   = (MIN_BYTES > HOLD) ? MIN_BYTES : HOLD;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic {
        ST_IDLE,
        ST_PAYLOAD
    } state_t;

    // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    // Input sample register, loaded only on enabled cycles.
    logic [7:0] rxd_s_q;
    logic       dv_s_q;
    logic       er_s_q;
    logic       mii_s_q;
    logic       smp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s_q <= '0;
            dv_s_q  <= 1'b0;
            er_s_q  <= 1'b0;
            mii_s_q <= 1'b0;
            smp_q   <= 1'b0;
        end else begin
            smp_q <= clk_enable;
            if (clk_enable) begin
                rxd_s_q <= gmii_rxd;
                dv_s_q  <= gmii_rx_dv;
                er_s_q  <= gmii_rx_er;
                mii_s_q <= mii_select;
            end
        end
    end

    state_t             state_q, state_d;
    logic               arm_q, arm_d;           // rx_dv seen low since last frame
    logic               prev5_q, prev5_d;       // previous MII nibble was 0x5
    logic               mode_mii_q, mode_mii_d; // nibble mode latched at SFD
    logic               nib_ph_q, nib_ph_d;     // 1 = low nibble held
    logic [3:0]         nib_lo_q, nib_lo_d;
    logic [31:0]        dl_q, dl_d;             // FCS delay line, [7:0] oldest
    logic [7:0]         pend_q, pend_d;         // byte awaiting tlast decision
    logic [CNT_W-1:0]   cnt_q, cnt_d;           // bytes after SFD, saturating
    logic [31:0]        crc_q, crc_d;
    logic               bad_q, bad_d;           // rx_er seen in this frame

    logic [7:0]         tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic               tuser_q, tuser_d;
    logic               err_frame_q, err_frame_d;
    logic               err_fcs_q, err_fcs_d;

    logic               mii_now;
    logic               sfd;
    logic               byte_stb;
    logic [7:0]         byte_val;
    logic               short_frame;
    logic               odd_nib;
    logic               fcs_bad;

    // State register and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            arm_q       <= 1'b0;
            prev5_q     <= 1'b0;
            mode_mii_q  <= 1'b0;
            nib_ph_q    <= 1'b0;
            nib_lo_q    <= '0;
            dl_q        <= '0;
            pend_q      <= '0;
            cnt_q       <= '0;
            crc_q       <= 32'hFFFF_FFFF;
            bad_q       <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            err_frame_q <= 1'b0;
            err_fcs_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm_d;
            prev5_q     <= prev5_d;
            mode_mii_q  <= mode_mii_d;
            nib_ph_q    <= nib_ph_d;
            nib_lo_q    <= nib_lo_d;
            dl_q        <= dl_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            bad_q       <= bad_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            err_frame_q <= err_frame_d;
            err_fcs_q   <= err_fcs_d;
        end
    end

    // Next-state and output logic; everything advances only on a held sample.
    always_comb begin
        state_d     = state_q;
        arm_d       = arm_q;
        prev5_d     = prev5_q;
        mode_mii_d  = mode_mii_q;
        nib_ph_d    = nib_ph_q;
        nib_lo_d    = nib_lo_q;
        dl_d        = dl_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        bad_d       = bad_q;
        tdata_d     = '0;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        tuser_d     = 1'b0;
        err_frame_d = 1'b0;
        err_fcs_d   = 1'b0;
        mii_now     = ENABLE_MII && mii_s_q;
        sfd         = 1'b0;
        byte_stb    = 1'b0;
        byte_val    = rxd_s_q;
        short_frame = 1'b0;
        odd_nib     = 1'b0;
        fcs_bad     = 1'b0;

        if (smp_q) begin
            case (state_q)
                ST_IDLE: begin
                    mode_mii_d = mii_now;
                    if (!dv_s_q) begin
                        arm_d   = 1'b1;
                        prev5_d = 1'b0;
                    end else if (arm_q) begin
                        if (mii_now) begin
                            sfd     = prev5_q && (rxd_s_q[3:0] == 4'hD);
                            prev5_d = (rxd_s_q[3:0] == 4'h5);
                        end else begin
                            sfd = (rxd_s_q == 8'hD5);
                        end
                    end
                    if (sfd) begin
                        state_d  = ST_PAYLOAD;
                        arm_d    = 1'b0;
                        prev5_d  = 1'b0;
                        nib_ph_d = 1'b0;
                        cnt_d    = '0;
                        crc_d    = 32'hFFFF_FFFF;
                        bad_d    = 1'b0;
                    end
                end

                ST_PAYLOAD: begin
                    if (dv_s_q) begin
                        if (er_s_q) begin
                            bad_d = 1'b1;
                        end
                        if (mode_mii_q) begin
                            nib_ph_d = !nib_ph_q;
                            if (nib_ph_q) begin
                                byte_stb = 1'b1;
                                byte_val = {rxd_s_q[3:0], nib_lo_q};
                            end else begin
                                nib_lo_d = rxd_s_q[3:0];
                            end
                        end else begin
                            byte_stb = 1'b1;
                        end

                        // A pending byte is known not to be last once another byte arrives.
                        if (byte_stb) begin
                            if (cnt_q >= CNT_W'(HOLD)) begin
                                tvalid_d = 1'b1;
                                tdata_d  = pend_q;
                            end
                            if (cnt_q >= CNT_W'(FCS_BYTES)) begin
                                pend_d = dl_q[7:0];
                                crc_d  = crc32_byte(crc_q, dl_q[7:0]);
                            end
                            dl_d = {byte_val, dl_q[31:8]};
                            if (cnt_q != CNT_W'(CNT_MAX)) begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end else begin
                        // rx_dv fall closes the frame; delay line now holds the FCS.
                        state_d     = ST_IDLE;
                        arm_d       = 1'b1;
                        prev5_d     = 1'b0;
                        short_frame = (cnt_q < CNT_W'(HOLD)) || (cnt_q < CNT_W'(MIN_BYTES));
                        odd_nib     = mode_mii_q && nib_ph_q;
                        fcs_bad     = (~crc_q != dl_q);
                        if (short_frame) begin
                            err_frame_d = 1'b1;
                        end else begin
                            tvalid_d    = 1'b1;
                            tdata_d     = pend_q;
                            tlast_d     = 1'b1;
                            tuser_d     = bad_q || odd_nib || fcs_bad;
                            err_frame_d = bad_q || odd_nib;
                            err_fcs_d   = fcs_bad;
                        end
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign m_axis.tdata    = tdata_q;
    assign m_axis.tvalid   = tvalid_q;
    assign m_axis.tlast    = tlast_q;
    assign m_axis.tuser    = tuser_q;
    assign error_bad_frame = err_frame_q;
    assign error_bad_fcs   = err_fcs_q;

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Scoreboard bench for gmii_rx_deframer: stimulus pushes expected output
// events (beats and error pulses) into a queue; a negedge monitor pops and
// compares every cycle in which the DUT shows a beat or an error pulse.
module tb_gmii_rx_deframer;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       clk_enable = 1'b0;
    logic       mii_select = 1'b0;
    logic [7:0] gmii_rxd   = 8'h00;
    logic       gmii_rx_dv = 1'b0;
    logic       gmii_rx_er = 1'b0;
    logic       error_bad_frame;
    logic       error_bad_fcs;

    gmii_rx_deframer_if axis ();

    gmii_rx_deframer #(.ENABLE_MII(1'b1), .MIN_BYTES(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_enable      (clk_enable),
        .mii_select      (mii_select),
        .gmii_rxd        (gmii_rxd),
        .gmii_rx_dv      (gmii_rx_dv),
        .gmii_rx_er      (gmii_rx_er),
        .m_axis          (axis),
        .error_bad_frame (error_bad_frame),
        .error_bad_fcs   (error_bad_fcs)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       u;
        logic       ef;
        logic       ec;
    } ev_t;

    ev_t        exp_q[$];
    int         pass_cnt   = 0;
    int         total_cnt  = 0;
    int         en_period  = 1;
    bit         abort_win  = 1'b0;
    int         abort_next = 0;
    bit         gap_chk    = 1'b0;
    longint     cyc        = 0;
    longint     last_beat  = -1000;
    logic [7:0] frm [64];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every visible output event is compared against the scoreboard.
    always @(negedge clk) begin
        ev_t act;
        ev_t e;
        act = {axis.tvalid, axis.tdata, axis.tlast, axis.tuser, error_bad_frame, error_bad_fcs};
        if (rst_n && (act.v || act.ef || act.ec)) begin
            if (act.v && gap_chk) begin
                total_cnt++;
                if (cyc - last_beat >= 10) pass_cnt++;
                else $display("FAIL mii_gap: got %0d clks between beats, required >= 10", cyc - last_beat);
            end
            if (act.v) last_beat = cyc;
            if (abort_win) begin
                total_cnt++;
                if (act.v && !act.l && !act.u && !act.ef && !act.ec && act.d == 8'(abort_next))
                    pass_cnt++;
                else
                    $display("FAIL abort_beat: got v=%b d=%h l=%b u=%b ef=%b ec=%b, required plain beat d=%h",
                             act.v, act.d, act.l, act.u, act.ef, act.ec, 8'(abort_next));
                abort_next++;
            end else if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_event: got v=%b d=%h l=%b u=%b ef=%b ec=%b, required no event",
                         act.v, act.d, act.l, act.u, act.ef, act.ec);
            end else begin
                e = exp_q.pop_front();
                total_cnt++;
                if (act == e) pass_cnt++;
                else $display("FAIL beat: got v=%b d=%h l=%b u=%b ef=%b ec=%b, required v=%b d=%h l=%b u=%b ef=%b ec=%b",
                              act.v, act.d, act.l, act.u, act.ef, act.ec, e.v, e.d, e.l, e.u, e.ef, e.ec);
            end
        end
    end

    // Bit-serial CRC-32 in LFSR form, LSB of each byte first.
    function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0);
        end
        return r;
    endfunction

    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        gmii_rxd   = d;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        clk_enable = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i < en_period; i++) begin
            clk_enable = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_outputs_zero(input string name);
        total_cnt++;
        if (!axis.tvalid && axis.tdata == 8'h00 && !axis.tlast && !axis.tuser &&
            !error_bad_frame && !error_bad_fcs)
            pass_cnt++;
        else
            $display("FAIL %s: got v=%b d=%h l=%b u=%b ef=%b ec=%b, required all 0", name,
                     axis.tvalid, axis.tdata, axis.tlast, axis.tuser, error_bad_frame, error_bad_fcs);
    endtask

    // 60 beats 0x00..0x3B; flags land on the tlast beat only.
    task automatic push_expect(input bit er, input bit fcs_flip);
        ev_t e;
        for (int i = 0; i < 60; i++) begin
            e.v  = 1'b1;
            e.d  = 8'(i);
            e.l  = (i == 59);
            e.u  = (i == 59) && (er || fcs_flip);
            e.ef = (i == 59) && er;
            e.ec = (i == 59) && fcs_flip;
            exp_q.push_back(e);
        end
    endtask

    // Preamble + SFD + 60-byte payload + FCS, then an idle gap.
    task automatic send_frame(input bit mii, input int er_at, input bit fcs_flip, input int rst_at);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 60; i++) begin
            frm[i] = 8'(i);
            c = crc_bits(c, frm[i]);
        end
        c = ~c;
        frm[60] = c[7:0];
        frm[61] = c[15:8];
        frm[62] = c[23:16];
        frm[63] = c[31:24] ^ 8'(fcs_flip);
        mii_select = mii;
        en_period  = mii ? 10 : 1;
        if (mii) begin
            repeat (15) drive(8'h05, 1'b1, 1'b0);
            drive(8'h0D, 1'b1, 1'b0);
        end else begin
            repeat (7) drive(8'h55, 1'b1, 1'b0);
            drive(8'hD5, 1'b1, 1'b0);
        end
        for (int i = 0; i < 64; i++) begin
            if (i == rst_at) begin
                abort_win = 1'b0;
                rst_n     = 1'b0;
                #1;
                check_outputs_zero("reset_mid_frame");
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            b = frm[i];
            if (mii) begin
                drive({4'h0, b[3:0]}, 1'b1, 1'b0);
                drive({4'h0, b[7:4]}, 1'b1, 1'b0);
            end else begin
                drive(b, 1'b1, i == er_at);
            end
        end
        idle(12);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        total_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else begin
            $display("FAIL %s_drain: got %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        ev_t e;
        clk_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        en_period = 1;
        idle(4);

        // 1G good frame
        push_expect(1'b0, 1'b0);
        send_frame(1'b0, -1, 1'b0, -1);
        drain("good_1g");

        // FCS corrupted in last byte
        push_expect(1'b0, 1'b1);
        send_frame(1'b0, -1, 1'b1, -1);
        drain("bad_fcs");

        // rx_er at payload byte 20
        push_expect(1'b1, 1'b0);
        send_frame(1'b0, 20, 1'b0, -1);
        drain("rx_er");

        // MII, clk_enable 1-in-10
        gap_chk = 1'b1;
        push_expect(1'b0, 1'b0);
        send_frame(1'b1, -1, 1'b0, -1);
        drain("mii_good");
        gap_chk = 1'b0;

        // Short frame: SFD + 3 bytes
        mii_select = 1'b0;
        en_period  = 1;
        idle(2);
        e = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_q.push_back(e);
        repeat (7) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        drive(8'hAA, 1'b1, 1'b0);
        drive(8'hBB, 1'b1, 1'b0);
        drive(8'hCC, 1'b1, 1'b0);
        idle(12);
        drain("short");

        // Reset at payload byte 30, then the frame again
        abort_next = 0;
        abort_win  = 1'b1;
        send_frame(1'b0, -1, 1'b0, 30);
        abort_win  = 1'b0;
        total_cnt++;
        if (abort_next >= 20 && abort_next <= 30) pass_cnt++;
        else $display("FAIL abort_partial: got %0d beats before reset, required 20..30", abort_next);
        push_expect(1'b0, 1'b0);
        send_frame(1'b0, -1, 1'b0, -1);
        drain("after_reset");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d events outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

endmodule
